// File: rtl/fft_input_buffer.sv
// fft_input_buffer: double-buffered bit-reversing sample loader feeding the FFT datapath.
module fft_input_buffer #(
  parameter int LOG2N    = 8,
  parameter int PRESCALE = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [31:0]      in_data_i,
  output logic             frame_ready_o,
  input  logic             rd_en_i,
  input  logic [LOG2N-1:0] rd_addr_i,
  output logic             rd_valid_o,
  output logic [31:0]      rd_real_o,
  output logic [31:0]      rd_img_o,
  input  logic             release_i,
  output logic             rd_bank_o
);
  localparam int N = 1 << LOG2N;
  logic [31:0]      mem_q [2*N];
  logic [LOG2N-1:0] wr_cnt_q, wr_cnt_d, wr_addr;
  logic             wr_bank_q, wr_bank_d, rd_bank_q, rd_bank_d;
  logic [1:0]       full_q, full_d;
  logic             rd_valid_q, rd_valid_d;
  logic [31:0]      rd_real_q, wr_data;
  logic             accept, done, rd_ok, rel_ok;
  always_comb begin
    in_ready_o    = !full_q[wr_bank_q];
    frame_ready_o = full_q[rd_bank_q];
    accept        = in_valid_i && in_ready_o;
    done          = accept && (&wr_cnt_q);
    rd_ok         = rd_en_i && frame_ready_o;
    rel_ok        = release_i && frame_ready_o;
    wr_cnt_d      = accept ? wr_cnt_q + LOG2N'(1) : wr_cnt_q;
    wr_bank_d     = wr_bank_q ^ done;
    rd_bank_d     = rd_bank_q ^ rel_ok;
    rd_valid_d    = rd_ok;
    wr_data       = $signed(in_data_i) >>> PRESCALE;
    // a completing write and a release never hit the same bank bit
    full_d        = full_q;
    if (done) full_d[wr_bank_q] = 1'b1;
    if (rel_ok) full_d[rd_bank_q] = 1'b0;
    for (int i = 0; i < LOG2N; i++) wr_addr[i] = wr_cnt_q[LOG2N-1-i];
    rd_valid_o    = rd_valid_q;
    rd_real_o     = rd_real_q;
    rd_img_o      = '0;
    rd_bank_o     = rd_bank_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_cnt_q   <= '0;
      wr_bank_q  <= 1'b0;
      rd_bank_q  <= 1'b0;
      full_q     <= 2'b00;
      rd_valid_q <= 1'b0;
      rd_real_q  <= '0;
    end else begin
      wr_cnt_q   <= wr_cnt_d;
      wr_bank_q  <= wr_bank_d;
      rd_bank_q  <= rd_bank_d;
      full_q     <= full_d;
      rd_valid_q <= rd_valid_d;
      if (rd_ok) rd_real_q <= mem_q[{rd_bank_q, rd_addr_i}];
    end
  end
  always_ff @(posedge clk) begin
    if (accept) mem_q[{wr_bank_q, wr_addr}] <= wr_data;
  end
endmodule
